muladd_pipe: RTL and testbench

- Parametrised, fully behavioural multiply-accumulate primitive; successor to the fixed 8x8+20 MULADD hard block in the fabric primitive library.
- Generic operand and accumulator widths, selectable signedness, optional input register stage, valid tracking, clock enable and sticky overflow flag.
- Instantiated in eFPGA user designs and as a simulation model for DSP tiles.

---
 rtl/muladd_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_muladd_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muladd_pipe.sv
// muladd_pipe: parametrised multiply-accumulate primitive.
//   q <= a*b + (acc_en ? (clr ? 0 : q) : c), with valid tracking, a clock
//   enable that freezes the whole pipe, and a sticky overflow flag.
//   Optional input register stage (IN_REG) and signed arithmetic (SIGNED).
//   Optional feature: define MULADD_PIPE_SAT_EN to saturate q on overflow
//   instead of wrapping modulo 2^C_WIDTH.
module muladd_pipe #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int C_WIDTH = 20,
    parameter int IN_REG  = 0,
    parameter int SIGNED  = 0
) (
    input  logic               UserCLK,
    input  logic               RESET,
    input  logic               ce,
    input  logic               valid_i,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic [C_WIDTH-1:0] c,
    input  logic               acc_en,
    input  logic               clr,
    output logic [C_WIDTH-1:0] q,
    output logic               valid_o,
    output logic               ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    generate
        if (C_WIDTH < P_WIDTH) begin : g_bad_width
            $error("muladd_pipe: C_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
    endgenerate

    // Operands as seen by the multiplier stage (registered or direct).
    logic [A_WIDTH-1:0] s0_a;
    logic [B_WIDTH-1:0] s0_b;
    logic [C_WIDTH-1:0] s0_c;
    logic               s0_acc;
    logic               s0_clr;
    logic               s0_valid;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [A_WIDTH-1:0] a_q;
            logic [B_WIDTH-1:0] b_q;
            logic [C_WIDTH-1:0] c_q;
            logic               acc_q;
            logic               clr_q;
            logic               valid_q;

            // Input capture stage; holds while ce is low.
            always_ff @(posedge UserCLK) begin
                if (RESET) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    c_q     <= '0;
                    acc_q   <= 1'b0;
                    clr_q   <= 1'b0;
                    valid_q <= 1'b0;
                end else if (ce) begin
                    a_q     <= a;
                    b_q     <= b;
                    c_q     <= c;
                    acc_q   <= acc_en;
                    clr_q   <= clr;
                    valid_q <= valid_i;
                end
            end

            assign s0_a     = a_q;
            assign s0_b     = b_q;
            assign s0_c     = c_q;
            assign s0_acc   = acc_q;
            assign s0_clr   = clr_q;
            assign s0_valid = valid_q;
        end else begin : g_no_in_reg
            assign s0_a     = a;
            assign s0_b     = b;
            assign s0_c     = c;
            assign s0_acc   = acc_en;
            assign s0_clr   = clr;
            assign s0_valid = valid_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage S1: full-width product
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] b_ext;
    logic [P_WIDTH-1:0] prod_d;
    logic [P_WIDTH-1:0] prod_q;
    logic [C_WIDTH-1:0] c1_q;
    logic               acc1_q;
    logic               clr1_q;
    logic               v1_q;

    // Extend operands to product width; low P bits of the product are then
    // exact for both signed and unsigned operands.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (SIGNED != 0) begin
            a_ext = P_WIDTH'($signed(s0_a));
            b_ext = P_WIDTH'($signed(s0_b));
        end else begin
            a_ext = P_WIDTH'(s0_a);
            b_ext = P_WIDTH'(s0_b);
        end
        prod_d = a_ext * b_ext;
    end

    // Multiplier pipeline register with control forwarded alongside.
    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            prod_q <= '0;
            c1_q   <= '0;
            acc1_q <= 1'b0;
            clr1_q <= 1'b0;
            v1_q   <= 1'b0;
        end else if (ce) begin
            prod_q <= prod_d;
            c1_q   <= s0_c;
            acc1_q <= s0_acc;
            clr1_q <= s0_clr;
            v1_q   <= s0_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: add, overflow detect, accumulator update
    // ------------------------------------------------------------------
    logic [C_WIDTH-1:0] ext_s;
    logic [C_WIDTH-1:0] addend_s;
    logic [C_WIDTH-1:0] sum_s;
    logic               carry_s;
    logic               ovf_op_s;
    logic [C_WIDTH-1:0] res_s;
    logic [C_WIDTH-1:0] q_d;
    logic [C_WIDTH-1:0] q_q;
    logic               valid_d;
    logic               valid_q;
    logic               ovf_d;
    logic               ovf_q;

    // Adder, overflow detection and next accumulator state.
    always_comb begin
        ext_s    = '0;
        addend_s = '0;
        ovf_op_s = 1'b0;
        res_s    = '0;
        q_d      = q_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        if (SIGNED != 0) begin
            ext_s = C_WIDTH'($signed(prod_q));
        end else begin
            ext_s = C_WIDTH'(prod_q);
        end

        if (acc1_q) begin
            if (clr1_q) begin
                addend_s = '0;
            end else begin
                addend_s = q_q;
            end
        end else begin
            addend_s = c1_q;
        end

        {carry_s, sum_s} = {1'b0, ext_s} + {1'b0, addend_s};

        if (SIGNED != 0) begin
            ovf_op_s = (ext_s[C_WIDTH-1] == addend_s[C_WIDTH-1]) &&
                       (sum_s[C_WIDTH-1] != ext_s[C_WIDTH-1]);
        end else begin
            ovf_op_s = carry_s;
        end

`ifdef MULADD_PIPE_SAT_EN
        // Overflow direction follows the product sign: both operands share it.
        if (ovf_op_s) begin
            if (SIGNED != 0) begin
                if (ext_s[C_WIDTH-1]) begin
                    res_s = {1'b1, {(C_WIDTH-1){1'b0}}};
                end else begin
                    res_s = {1'b0, {(C_WIDTH-1){1'b1}}};
                end
            end else begin
                res_s = '1;
            end
        end else begin
            res_s = sum_s;
        end
`else
        res_s = sum_s;
`endif

        if (v1_q) begin
            q_d     = res_s;
            valid_d = 1'b1;
            ovf_d   = (clr1_q ? 1'b0 : ovf_q) | ovf_op_s;
        end else begin
            q_d     = q_q;
            valid_d = 1'b0;
            ovf_d   = ovf_q;
        end
    end

    // Result, valid and sticky overflow registers; frozen while ce is low.
    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q       = q_q;
    assign valid_o = valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_muladd_pipe.sv
// Self-checking bench for muladd_pipe: two instances (unsigned/no input
// register, signed/with input register) share stimulus; each has its own
// reference model and scoreboard queue, drained by a negedge monitor.
module tb_muladd_pipe;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int CW = 20;

`ifdef MULADD_PIPE_SAT_EN
    localparam longint OVF_Q = 1048575;
`else
    localparam longint OVF_Q = 0;
`endif

    logic          UserCLK = 1'b0;
    logic          RESET;
    logic          ce;
    logic          valid_i;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    logic          acc_en;
    logic          clr;
    logic [CW-1:0] q0, q1;
    logic          v0, v1, o0, o1;

    always #5 UserCLK = ~UserCLK;

    muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .IN_REG(0), .SIGNED(0)) dut0 (
        .UserCLK(UserCLK), .RESET(RESET), .ce(ce), .valid_i(valid_i),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .clr(clr),
        .q(q0), .valid_o(v0), .ovf(o0)
    );

    muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .IN_REG(1), .SIGNED(1)) dut1 (
        .UserCLK(UserCLK), .RESET(RESET), .ce(ce), .valid_i(valid_i),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .clr(clr),
        .q(q1), .valid_o(v1), .ovf(o1)
    );

    typedef struct {
        logic [CW-1:0] q;
        logic          o;
        int unsigned   at;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned ecnt = 0;
    bit          en_last = 1'b0;
    bit          hold_last = 1'b0;
    bit          started = 1'b0;
    longint      m_q[2];
    bit          m_ovf[2];
    logic [CW-1:0] pq[2];
    logic          pv[2];
    logic          po[2];

    // Enabled-cycle counter: latency is measured in ce=1 cycles.
    always @(posedge UserCLK) begin
        en_last   <= ce && !RESET;
        hold_last <= !ce && !RESET;
        if (ce && !RESET) ecnt <= ecnt + 1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint sx(longint v, int w);
        longint one = 1;
        if (v >= (one << (w - 1))) return v - (one << w);
        return v;
    endfunction

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic void model_op(int d, logic [AW-1:0] av, logic [BW-1:0] bv,
                                     logic [CW-1:0] cv, logic acc, logic cl,
                                     output logic [CW-1:0] rq, output logic ro);
        longint one = 1;
        longint md = one << CW;
        longint pa, pb, pc, x, s, maxv, minv;
        bit ov;
        if (d == 1) begin
            pa   = sx(longint'(av), AW);
            pb   = sx(longint'(bv), BW);
            pc   = sx(longint'(cv), CW);
            x    = acc ? (cl ? 0 : sx(m_q[d], CW)) : pc;
            maxv = (one << (CW - 1)) - 1;
            minv = -(one << (CW - 1));
        end else begin
            pa   = longint'(av);
            pb   = longint'(bv);
            pc   = longint'(cv);
            x    = acc ? (cl ? 0 : m_q[d]) : pc;
            maxv = md - 1;
            minv = 0;
        end
        s  = pa * pb + x;
        ov = (s > maxv) || (s < minv);
`ifdef MULADD_PIPE_SAT_EN
        if (s > maxv) s = maxv;
        else if (s < minv) s = minv;
`endif
        m_q[d]   = ((s % md) + md) % md;
        m_ovf[d] = (cl ? 1'b0 : m_ovf[d]) | ov;
        rq = m_q[d][CW-1:0];
        ro = m_ovf[d];
    endfunction

    // Issue one valid op; x0/x1 >= 0 give the expected q for dut0/dut1 directly.
    task automatic issue(logic [AW-1:0] ia, logic [BW-1:0] ib, logic [CW-1:0] ic,
                         logic iacc, logic icl, longint x0, longint x1);
        exp_t e;
        logic [CW-1:0] rq;
        logic ro;
        ce = 1'b1; valid_i = 1'b1; a = ia; b = ib; c = ic; acc_en = iacc; clr = icl;
        @(posedge UserCLK); #1;
        model_op(0, ia, ib, ic, iacc, icl, rq, ro);
        e.q = (x0 >= 0) ? x0[CW-1:0] : rq; e.o = ro; e.at = ecnt + 1;
        sb0.push_back(e);
        model_op(1, ia, ib, ic, iacc, icl, rq, ro);
        e.q = (x1 >= 0) ? x1[CW-1:0] : rq; e.o = ro; e.at = ecnt + 2;
        sb1.push_back(e);
        valid_i = 1'b0;
    endtask

    // One cycle without a captured op; garbage on the inputs.
    task automatic idle(logic ice);
        ce = ice;
        valid_i = ice ? 1'b0 : 1'($urandom_range(0, 1));
        a = AW'($urandom); b = BW'($urandom); c = CW'($urandom);
        acc_en = 1'($urandom); clr = 1'($urandom);
        @(posedge UserCLK); #1;
        valid_i = 1'b0;
    endtask

    task automatic do_reset(bit with_op);
        RESET = 1'b1;
        ce = 1'($urandom_range(0, 1));
        if (with_op) begin
            valid_i = 1'b1; a = AW'($urandom); b = BW'($urandom); c = CW'($urandom);
            acc_en = 1'b0; clr = 1'b0;
        end
        @(posedge UserCLK); #1;
        RESET = 1'b0; valid_i = 1'b0; ce = 1'b1;
        chk("rst_q0", 32'(q0), 32'd0);
        chk("rst_v0", 32'(v0), 32'd0);
        chk("rst_o0", 32'(o0), 32'd0);
        chk("rst_q1", 32'(q1), 32'd0);
        chk("rst_v1", 32'(v1), 32'd0);
        chk("rst_o1", 32'(o1), 32'd0);
        sb0.delete(); sb1.delete();
        m_q[0] = 0; m_q[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    endtask

    task automatic mon(int d, logic v, logic [CW-1:0] qq, logic oo);
        exp_t e;
        bit have, ev;
        have = 1'b0;
        if (d == 0) begin
            have = sb0.size() > 0;
            if (have) e = sb0[0];
        end else begin
            have = sb1.size() > 0;
            if (have) e = sb1[0];
        end
        if (en_last) begin
            ev = have && (e.at == ecnt);
            checks++;
            if (v !== ev) begin
                errors++;
                $display("FAIL valid_o dut%0d cycle %0d: got %b expected %b", d, ecnt, v, ev);
            end
            if (ev) begin
                if (d == 0) void'(sb0.pop_front());
                else void'(sb1.pop_front());
                checks++;
                if (qq !== e.q || oo !== e.o) begin
                    errors++;
                    $display("FAIL result dut%0d: got q=%0d ovf=%b expected q=%0d ovf=%b",
                             d, qq, oo, e.q, e.o);
                end
            end
        end else if (hold_last) begin
            checks++;
            if (v !== pv[d] || qq !== pq[d] || oo !== po[d]) begin
                errors++;
                $display("FAIL ce_hold dut%0d: got v=%b q=%0d ovf=%b expected v=%b q=%0d ovf=%b",
                         d, v, qq, oo, pv[d], pq[d], po[d]);
            end
        end
        pv[d] = v; pq[d] = qq; po[d] = oo;
    endtask

    // Monitor: compares outputs after every clock edge.
    always @(negedge UserCLK) begin
        if (started) begin
            mon(0, v0, q0, o0);
            mon(1, v1, q1, o1);
        end
    end

    task automatic drain();
        repeat (5) idle(1'b1);
    endtask

    initial begin
        RESET = 1'b0; ce = 1'b0; valid_i = 1'b0;
        a = '0; b = '0; c = '0; acc_en = 1'b0; clr = 1'b0;
        m_q[0] = 0; m_q[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        @(posedge UserCLK); #1;
        do_reset(1'b0);
        started = 1'b1;

        // Basic multiply-add.
        issue(8'd3, 8'd5, 20'd7, 1'b0, 1'b0, 22, 22);
        drain();

        // Back-to-back accumulate with clr on the first op.
        issue(8'd2, 8'd3, 20'd0, 1'b1, 1'b1, 6, 6);
        issue(8'd4, 8'd4, 20'd0, 1'b1, 1'b0, 22, 22);
        issue(8'd1, 8'd1, 20'd0, 1'b1, 1'b0, 23, 23);
        drain();

        // -128 * -128 then accumulate -1*1 (signed instance).
        issue(8'h80, 8'h80, 20'd0, 1'b0, 1'b0, 16384, 16384);
        issue(8'hFF, 8'h01, 20'd0, 1'b1, 1'b0, 16639, 16383);
        drain();

        // Unsigned overflow at the top of the range, then a clearing op.
        issue(8'd0, 8'd0, 20'hFFFFF, 1'b0, 1'b0, 1048575, 1048575);
        issue(8'd1, 8'd1, 20'd0, 1'b1, 1'b0, OVF_Q, 0);
        issue(8'd2, 8'd2, 20'd0, 1'b1, 1'b1, 4, 4);
        drain();

        // Clock enable low for two cycles right after issue.
        issue(8'd10, 8'd10, 20'd0, 1'b0, 1'b0, 100, 100);
        idle(1'b0);
        idle(1'b0);
        drain();

        // Reset with operations in flight, then a clean accumulate.
        issue(8'd7, 8'd9, 20'd3, 1'b0, 1'b0, -1, -1);
        issue(8'd11, 8'd13, 20'd5, 1'b1, 1'b0, -1, -1);
        do_reset(1'b1);
        repeat (3) idle(1'b1);
        issue(8'd2, 8'd3, 20'd0, 1'b1, 1'b0, 6, 6);
        drain();

        // Randomised mix of ops, bubbles and ce stalls.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 5));
            if (r == 0) idle(1'b0);
            else if (r == 1) idle(1'b1);
            else issue(AW'($urandom), BW'($urandom), CW'($urandom),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), -1, -1);
        end
        drain();

        chk("sb0_empty", 32'(sb0.size()), 32'd0);
        chk("sb1_empty", 32'(sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
